uart_tx_scheduler: RTL and testbench

//  Shares one UART transmitter among NUM_REQ requesters using round-robin arbitration.

---
 rtl/uart_tx_scheduler_if.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 119 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Requester handshake and transmitter-side signals of uart_tx_scheduler.
// master is the scheduler's view; slave is the view of the clients plus transmitter.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_parity_en;
  logic [NUM_REQ-1:0]            req_odd_even;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_en;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_parity_en;
  logic                          tx_odd_even;
  logic                          tx_tick;
  logic                          tx_busy;
  logic [ID_W-1:0]               grant_id;
  logic                          active;
  logic                          launch_err;

  modport master (
    input  req_valid, req_data, req_parity_en, req_odd_even, tx_busy,
    output req_ready, tx_en, tx_data, tx_parity_en, tx_odd_even, tx_tick,
           grant_id, active, launch_err
  );

  modport slave (
    output req_valid, req_data, req_parity_en, req_odd_even, tx_busy,
    input  req_ready, tx_en, tx_data, tx_parity_en, tx_odd_even, tx_tick,
           grant_id, active, launch_err
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters,
// plus the free-running bit-rate tick generator for that transmitter.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_scheduler_if.master bus
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state, state_nxt;
  logic [TICK_W-1:0]     tick_cnt;
  logic                  tick_q;
  logic [TO_W-1:0]       wait_cnt;
  logic [ID_W-1:0]       grant_q, win;
  logic                  win_found, accept, timeout;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  parity_en_q, odd_even_q, launch_err_q;
  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q   <= (tick_cnt == TICK_LAST);
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  // Search begins just after the last grant, so reset (grant_q = NUM_REQ-1) favours requester 0.
  always_comb begin
    int sum;
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    win       = grant_q;
    win_found = 1'b0;
    sum       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(grant_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      if (!win_found && bus.req_valid[ID_W'(sum)]) begin
        win       = ID_W'(sum);
        win_found = 1'b1;
      end
    end
  end

  assign accept = (state == IDLE) && rst && !bus.tx_busy && win_found;

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    unique case (state)
      IDLE:      if (accept) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A timed-out launch still records its grant, so the rotation moves past it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_q      <= ID_W'(NUM_REQ - 1);
      data_q       <= '0;
      parity_en_q  <= 1'b0;
      odd_even_q   <= 1'b0;
      wait_cnt     <= '0;
      launch_err_q <= 1'b0;
    end else begin
      launch_err_q <= timeout;
      wait_cnt     <= (state == WAIT_BUSY) ? wait_cnt + TO_W'(1) : '0;
      if (accept) begin
        grant_q     <= win;
        data_q      <= req_data_arr[win];
        parity_en_q <= bus.req_parity_en[win];
        odd_even_q  <= bus.req_odd_even[win];
      end
    end
  end

  assign bus.req_ready    = accept ? (NUM_REQ'(1) << win) : '0;
  assign bus.tx_en        = (state == LAUNCH);
  assign bus.tx_data      = data_q;
  assign bus.tx_parity_en = parity_en_q;
  assign bus.tx_odd_even  = odd_even_q;
  assign bus.tx_tick      = tick_q;
  assign bus.grant_id     = grant_q;
  assign bus.active       = (state != IDLE);
  assign bus.launch_err   = launch_err_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized
// traffic checked against a round-robin reference model and a transmitter model.
module tb_uart_tx_scheduler;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) ifc ();

  uart_tx_scheduler #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .BUSY_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.master)
  );

  always #5 clk = ~clk;

  // Clock edges seen with reset released; the tick is due whenever this is a multiple of CPB.
  always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

  // Reference state
  logic [DW-1:0] m_data [NR];
  logic          m_pe   [NR];
  logic          m_oe   [NR];
  int            exp_last = NR - 1;
  logic [DW-1:0] exp_data;
  logic          exp_pe, exp_oe;
  bit            have_cap = 0;
  bit            tick_armed = 0;
  int            grant_log[$];

  // Transmitter model
  bit model_en = 0;
  int busy_left = 0;
  int char_time = 4;

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int w);
    return (w >= 0) ? (NR'(1) << w) : '0;
  endfunction

  task automatic cycle();
    logic exp_tick;
    @(negedge clk);
    if (model_en) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) ifc.tx_busy = 1'b0;
      end else if (ifc.tx_en === 1'b1) begin
        busy_left   = char_time;
        ifc.tx_busy = 1'b1;
      end
    end
    if (tick_armed) begin
      exp_tick = (cyc != 0) && (cyc % CPB == 0);
      checks++;
      if (ifc.tx_tick !== exp_tick) begin
        errors++;
        $display("FAIL tick cyc=%0d got=%b want=%b", cyc, ifc.tx_tick, exp_tick);
      end
    end
  endtask

  task automatic set_req(input int i);
    m_data[i] = DW'($urandom);
    m_pe[i]   = 1'($urandom);
    m_oe[i]   = 1'($urandom);
    ifc.req_data[i*DW +: DW] = m_data[i];
    ifc.req_parity_en[i]     = m_pe[i];
    ifc.req_odd_even[i]      = m_oe[i];
    ifc.req_valid[i]         = 1'b1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      cycle();
      if (ifc.active === 1'b0 && ifc.tx_busy === 1'b0) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout active=%b busy=%b", ifc.active, ifc.tx_busy);
  endtask

  task automatic apply_reset(input logic busy_level);
    rst           = 1'b0;
    ifc.req_valid = '0;
    model_en      = 0;
    busy_left     = 0;
    ifc.tx_busy   = busy_level;
    repeat (2) cycle();
    rst      = 1'b1;
    exp_last = NR - 1;
    have_cap = 0;
  endtask

  task automatic test_reset();
    int ticks = 0;
    int first_tick = -1;
    rst = 1'b0;
    ifc.req_valid = '1;
    repeat (3) cycle();
    #1;
    checks++;
    if (ifc.req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b want=0000", ifc.req_ready); end
    checks++;
    if ({ifc.tx_en, ifc.tx_tick, ifc.launch_err, ifc.active} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got en/tick/err/act=%b%b%b%b want=0000", ifc.tx_en, ifc.tx_tick, ifc.launch_err, ifc.active);
    end
    checks++;
    if ({ifc.tx_data, ifc.tx_parity_en, ifc.tx_odd_even} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h/%b/%b want=00/0/0", ifc.tx_data, ifc.tx_parity_en, ifc.tx_odd_even);
    end
    checks++;
    if (ifc.grant_id !== 2'd3) begin errors++; $display("FAIL reset_grant got=%0d want=3", ifc.grant_id); end
    ifc.req_valid = '0;
    tick_armed = 1;
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (ifc.tx_tick === 1'b1) begin
        ticks++;
        if (first_tick < 0) first_tick = k + 1;
      end
      checks++;
      if (ifc.tx_en !== 1'b0 || ifc.req_ready !== '0) begin
        errors++;
        $display("FAIL idle_quiet k=%0d tx_en=%b ready=%b want 0/0000", k, ifc.tx_en, ifc.req_ready);
      end
    end
    checks++;
    if (first_tick != CPB || ticks != 2) begin
      errors++;
      $display("FAIL first_tick got first=%0d count=%0d want first=%0d count=2", first_tick, ticks, CPB);
    end
  endtask

  task automatic test_single();
    cycle();
    ifc.req_data[2*DW +: DW] = 8'hA5;
    ifc.req_parity_en[2]     = 1'b1;
    ifc.req_odd_even[2]      = 1'b0;
    ifc.req_valid            = 4'b0100;
    #1;
    checks++;
    if (ifc.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b want=0100", ifc.req_ready); end
    model_en  = 1;
    char_time = 5;
    cycle();
    ifc.req_valid = '0;
    #1;
    checks++;
    if (ifc.req_ready !== '0 || ifc.tx_en !== 1'b1) begin
      errors++;
      $display("FAIL single_launch got ready=%b tx_en=%b want 0000/1", ifc.req_ready, ifc.tx_en);
    end
    checks++;
    if ({ifc.tx_data, ifc.tx_parity_en, ifc.tx_odd_even, ifc.grant_id} !== {8'hA5, 1'b1, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL single_capture got data=%h pe=%b oe=%b gid=%0d want a5/1/0/2",
               ifc.tx_data, ifc.tx_parity_en, ifc.tx_odd_even, ifc.grant_id);
    end
    exp_last = 2;
    cycle();
    checks++;
    if (ifc.tx_en !== 1'b0) begin errors++; $display("FAIL single_pulse got tx_en=%b want=0", ifc.tx_en); end
    wait_idle();
  endtask

  // Runs n accepts; rnd=0 keeps every requester valid, rnd=1 uses random arrivals and drops.
  task automatic serve(input int n, input bit rnd);
    int done = 0;
    int budget = n * 60;
    int stall = 0;
    int w;
    bit acc_prev = 0;
    logic [NR-1:0] rdy;
    model_en = 1;
    while (done < n && budget > 0) begin
      budget--;
      #1;
      rdy = ifc.req_ready;
      acc_prev = 0;
      if (rdy !== '0) begin
        w = rr_pick(ifc.req_valid, exp_last);
        checks++;
        if (rdy !== onehot(w) || ifc.tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL grant got=%b want=%b busy=%b", rdy, onehot(w), ifc.tx_busy);
        end
        if (w >= 0) begin
          exp_last = w;
          exp_data = m_data[w];
          exp_pe   = m_pe[w];
          exp_oe   = m_oe[w];
        end
        have_cap  = 1;
        acc_prev  = 1;
        done++;
        grant_log.push_back(w);
        char_time = $urandom_range(2, 12);
        stall = 0;
      end else if (ifc.tx_busy === 1'b0 && ifc.req_valid !== '0) begin
        stall++;
        checks++;
        if (stall > 2) begin
          errors++;
          $display("FAIL starve valid=%b ready=%b stalled=%0d", ifc.req_valid, rdy, stall);
          stall = 0;
        end
      end else begin
        stall = 0;
      end
      cycle();
      checks++;
      if (ifc.tx_en !== acc_prev || ifc.launch_err !== 1'b0) begin
        errors++;
        $display("FAIL launch got tx_en=%b err=%b want %b/0", ifc.tx_en, ifc.launch_err, acc_prev);
      end
      if (have_cap) begin
        checks++;
        if ({ifc.tx_data, ifc.tx_parity_en, ifc.tx_odd_even} !== {exp_data, exp_pe, exp_oe} ||
            ifc.grant_id !== 2'(exp_last)) begin
          errors++;
          $display("FAIL capture got %h/%b/%b gid=%0d want %h/%b/%b gid=%0d", ifc.tx_data, ifc.tx_parity_en,
                   ifc.tx_odd_even, ifc.grant_id, exp_data, exp_pe, exp_oe, exp_last);
        end
      end
      if (acc_prev) begin
        if (rnd) ifc.req_valid[exp_last] = 1'b0;
        else     set_req(exp_last);
      end
      if (rnd) begin
        for (int i = 0; i < NR; i++) begin
          if (!ifc.req_valid[i]) begin
            if ($urandom_range(0, 5) == 0) set_req(i);
          end else if ($urandom_range(0, 39) == 0) begin
            ifc.req_valid[i] = 1'b0;
          end
        end
      end
    end
    checks++;
    if (done != n) begin errors++; $display("FAIL serve_budget got=%0d accepts want=%0d", done, n); end
    ifc.req_valid = '0;
    wait_idle();
  endtask

  task automatic test_round_robin();
    apply_reset(1'b0);
    grant_log.delete();
    for (int i = 0; i < NR; i++) set_req(i);
    serve(8, 1'b0);
    checks++;
    if (grant_log.size() != 8) begin
      errors++;
      $display("FAIL rr_count got=%0d want=8", grant_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (grant_log[k] != k % NR) begin
          errors++;
          $display("FAIL rr_order idx=%0d got=%0d want=%0d", k, grant_log[k], k % NR);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int g;
    model_en    = 0;
    ifc.tx_busy = 1'b0;
    have_cap    = 0;
    cycle();
    for (int i = 0; i < NR; i++) set_req(i);
    #1;
    g = rr_pick(ifc.req_valid, exp_last);
    checks++;
    if (ifc.req_ready !== onehot(g)) begin errors++; $display("FAIL to_grant got=%b want=%b", ifc.req_ready, onehot(g)); end
    exp_last = g;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      checks++;
      if (ifc.launch_err !== 1'b0 || ifc.tx_en !== (k == 1)) begin
        errors++;
        $display("FAIL to_early k=%0d got err=%b tx_en=%b want 0/%b", k, ifc.launch_err, ifc.tx_en, k == 1);
      end
    end
    cycle();
    checks++;
    if (ifc.launch_err !== 1'b1 || ifc.active !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse got err=%b active=%b want 1/0", ifc.launch_err, ifc.active);
    end
    #1;
    checks++;
    if (ifc.req_ready !== onehot((g + 1) % NR)) begin
      errors++;
      $display("FAIL to_next got=%b want=%b", ifc.req_ready, onehot((g + 1) % NR));
    end
    exp_last = (g + 1) % NR;
    cycle();
    ifc.req_valid = '0;
    checks++;
    if (ifc.launch_err !== 1'b0) begin errors++; $display("FAIL to_width got err=%b want=0", ifc.launch_err); end
    wait_idle();
  endtask

  task automatic test_busy_block();
    rst = 1'b0;
    model_en = 0;
    busy_left = 0;
    ifc.tx_busy = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i);
    repeat (2) cycle();
    rst = 1'b1;
    exp_last = NR - 1;
    have_cap = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      checks++;
      if (ifc.req_ready !== '0) begin errors++; $display("FAIL busy_hold k=%0d got=%b want=0000", k, ifc.req_ready); end
      cycle();
    end
    ifc.tx_busy = 1'b0;
    #1;
    checks++;
    if (ifc.req_ready !== 4'b0001) begin errors++; $display("FAIL busy_release got=%b want=0001", ifc.req_ready); end
    model_en  = 1;
    char_time = 4;
    cycle();
    ifc.req_valid = '0;
    exp_last = 0;
    checks++;
    if (ifc.tx_en !== 1'b1 || ifc.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL busy_launch got tx_en=%b gid=%0d want 1/0", ifc.tx_en, ifc.grant_id);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int w;
    ifc.req_valid = '0;
    set_req(1);
    model_en  = 1;
    char_time = 30;
    #1;
    w = rr_pick(ifc.req_valid, exp_last);
    checks++;
    if (ifc.req_ready !== onehot(w)) begin errors++; $display("FAIL mid_grant got=%b want=%b", ifc.req_ready, onehot(w)); end
    cycle();
    ifc.req_valid = '0;
    repeat (5) cycle();
    checks++;
    if (ifc.active !== 1'b1 || ifc.tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got active=%b busy=%b want 1/1", ifc.active, ifc.tx_busy);
    end
    rst = 1'b0;
    model_en = 0;
    busy_left = 0;
    ifc.tx_busy = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i);
    #1;
    checks++;
    if (ifc.req_ready !== '0) begin errors++; $display("FAIL mid_rst_ready got=%b want=0000", ifc.req_ready); end
    cycle();
    checks++;
    if ({ifc.active, ifc.tx_en, ifc.launch_err} !== 3'b000 || ifc.grant_id !== 2'd3 || ifc.tx_data !== '0) begin
      errors++;
      $display("FAIL mid_rst got act/en/err=%b%b%b gid=%0d data=%h want 000/3/00",
               ifc.active, ifc.tx_en, ifc.launch_err, ifc.grant_id, ifc.tx_data);
    end
    rst = 1'b1;
    exp_last = NR - 1;
    have_cap = 0;
    #1;
    checks++;
    if (ifc.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first got=%b want=0001", ifc.req_ready); end
    exp_last  = 0;
    model_en  = 1;
    char_time = 3;
    cycle();
    ifc.req_valid = '0;
    wait_idle();
  endtask

  task automatic test_random();
    apply_reset(1'b0);
    serve(40, 1'b1);
  endtask

  initial begin
    ifc.req_valid     = '0;
    ifc.req_data      = '0;
    ifc.req_parity_en = '0;
    ifc.req_odd_even  = '0;
    ifc.tx_busy       = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_busy_block();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
